perceptron_uart_ctrl: RTL and testbench
=======================================

Name: perceptron_uart_ctrl

Overview:
Command sequencer between the byte-level UART receiver/transmitter and the perceptron datapath. It parses single-byte opcodes plus payload from the RX byte stream and writes weights, bias and inputs into the perceptron register file. It triggers an evaluation, waits for completion, and returns the result (or a status/error byte) over TX. It is instantiated inside the perceptron top, between the UART blocks and the perceptron core.

Parameters:
N_INPUTS, 4, number of perceptron inputs/weights (1..16)
DATA_W, 8, width of weights, inputs, bias and result; fixed at one UART byte
IDX_W, 4, width of the weight/input index bus; must satisfy 2**IDX_W >= N_INPUTS
TIMEOUT_CYCLES, 120000, inter-byte timeout in clk cycles (10 ms at 12 MHz); used only with the optional feature

Ports:
clk  in  1  system clock (12 MHz)
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte from UART RX
rx_valid  in  1  one-cycle strobe; rx_data is valid
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle strobe; launches transmission of tx_data
tx_busy  in  1  UART TX busy; tx_start is issued only when this is low
p_wr_en  out  1  one-cycle write strobe into the perceptron register file
p_wr_sel  out  2  write target: 0=weight, 1=input, 2=bias
p_wr_idx  out  IDX_W  weight/input index
p_wr_data  out  DATA_W  value written
p_start  out  1  one-cycle evaluation start
p_done  in  1  one-cycle completion strobe from the perceptron
p_result  in  DATA_W  perceptron output; valid while p_done is high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; all outputs 0; byte counter 0; error code 0. Reset mid-command or mid-evaluation abandons the operation, and no TX byte is sent for it.
- Opcodes, received in IDLE:
  - 0x57 'W': followed by N_INPUTS weight bytes.
  - 0x58 'X': followed by N_INPUTS input bytes.
  - 0x42 'B': followed by 1 bias byte.
  - 0x52 'R': run the perceptron.
  - 0x53 'S': return status.
  - Any other byte: error code 0x01, reply 0xEE.
- States: IDLE, LOAD, RUN, WAIT_DONE, SEND, ERR.
- IDLE:
  - rx_valid with 'W'/'X'/'B': latch the target, clear the counter, go to LOAD.
  - 'R': go to RUN.
  - 'S': load tx byte {7'b0, last_err!=0}, go to SEND.
  - Unknown opcode: go to ERR.
- LOAD: each rx_valid produces, on the same edge, p_wr_en=1 for one cycle with p_wr_idx=counter and p_wr_data=rx_data, then the counter increments.
  - After the last byte (counter==N_INPUTS-1, or the single bias byte), load ack 0x06 and go to SEND.
  - Bytes arriving in LOAD are always payload, never opcodes.
- RUN: assert p_start for exactly one cycle, go to WAIT_DONE.
- WAIT_DONE: on p_done, capture p_result into the tx byte and go to SEND.
  - rx_valid in WAIT_DONE is dropped and sets error code 0x02; the result is still sent.
  - p_done in any other state is ignored.
- SEND: wait for tx_busy=0, then pulse tx_start for one cycle with tx_data held stable that cycle and thereafter until the next load. Return to IDLE. rx_valid in SEND is dropped (error 0x02).
- ERR: load 0xEE, go to SEND.
- Reading status ('S') clears the error code after the reply is loaded.
- Latency: 'R' to p_start is 1 cycle. p_done to tx_start is 1 cycle if tx_busy=0.
- Simultaneous rx_valid and p_done in WAIT_DONE: the result wins, the byte is dropped, and error 0x02 is set.

Optional Feature:
PERCEPTRON_CTRL_TIMEOUT_EN.
- Defined: in LOAD, a counter of width $clog2(TIMEOUT_CYCLES+1) restarts on every rx_valid. When it reaches TIMEOUT_CYCLES, the partial command is aborted: error 0x03, reply 0xEE via ERR. Registers already written are not rolled back.
- Undefined: no counter exists and LOAD waits indefinitely.

Decomposition:
- Shared package perceptron_pkg holds:
  - state encoding
  - opcode constants (OP_W, OP_X, OP_B, OP_R, OP_S)
  - reply constants (ACK=0x06, NAK=0xEE)
  - error codes (ERR_OPC=1, ERR_OVR=2, ERR_TMO=3)
  - wr_sel encoding
- One sub-module, perceptron_tx_slot: a one-byte holding register with load/tx_start/tx_busy handshake. The FSM stays in the top block.

Test Plan:
- Send 'W',10,20,30,40 -> four p_wr_en pulses, sel=0, idx 0..3, data 10,20,30,40; then tx_start with tx_data=0x06.
- Send 'B',0xF0 -> one write with sel=2, data 0xF0; ack 0x06.
- Send 'R'; return p_done with p_result=0x01 after 5 cycles -> p_start pulse 1 cycle after rx; tx_start with 0x01 one cycle after p_done; busy low afterwards.
- Send 0x7A -> reply 0xEE. Then 'S' -> reply 0x01. Then 'S' again -> reply 0x00.
- Hold tx_busy=1 for 50 cycles during SEND -> no tx_start until tx_busy falls; then a single pulse with correct data.
- Assert rst after 2 of 4 'X' payload bytes -> outputs 0 next cycle, no reply sent. A following 'S' replies 0x00.
- With PERCEPTRON_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 'X',5 then idle 100 cycles -> reply 0xEE. 'S' -> 0x01.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron UART command sequencer:
// FSM state encoding, opcode/reply bytes, error codes and write-target select.
package perceptron_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_SEND      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_W = 2'd0,
        SEL_X = 2'd1,
        SEL_B = 2'd2
    } wr_sel_t;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_X = 8'h58;
    localparam logic [7:0] OP_B = 8'h42;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_S = 8'h53;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OPC  = 2'd1;
    localparam logic [1:0] ERR_OVR  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Status reply: bit 0 flags that an error has been recorded since the last read.
    function automatic logic [7:0] status_byte(input logic [1:0] err);
        return {7'b0, (err != ERR_NONE)};
    endfunction

endpackage

// File: rtl/perceptron_uart_ctrl_if.sv
// Byte/handshake bundle between the command sequencer, the UART RX/TX blocks
// and the perceptron register file. The sequencer uses the master modport.
interface perceptron_uart_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              p_wr_en;
    logic [1:0]        p_wr_sel;
    logic [IDX_W-1:0]  p_wr_idx;
    logic [DATA_W-1:0] p_wr_data;
    logic              p_start;
    logic              p_done;
    logic [DATA_W-1:0] p_result;

    modport master (
        input  rx_data, rx_valid, tx_busy, p_done, p_result,
        output tx_data, tx_start, p_wr_en, p_wr_sel, p_wr_idx, p_wr_data, p_start
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, p_done, p_result,
        input  tx_data, tx_start, p_wr_en, p_wr_sel, p_wr_idx, p_wr_data, p_start
    );
endinterface

// File: rtl/perceptron_tx_slot.sv
// One-byte transmit holding register. A load captures the reply byte; while
// send is high the slot launches it with a single tx_start pulse as soon as
// the UART transmitter is idle. tx_data stays put until the next load.
module perceptron_tx_slot
    import perceptron_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       send,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start
);

    // Hold the reply byte and fire one start strobe when the transmitter is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= send && !tx_busy;
            if (load) begin
                tx_data <= load_data;
            end
        end
    end

endmodule

// File: rtl/perceptron_uart_ctrl.sv
// Command sequencer between the UART byte stream and the perceptron core.
// Parses opcodes (W/X/B payload loads, R run, S status), writes the register
// file, runs an evaluation and returns ack/result/status/NAK bytes over TX.
// Optional inter-byte timeout in LOAD: define PERCEPTRON_CTRL_TIMEOUT_EN.
module perceptron_uart_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS       = 4,
    parameter int DATA_W         = 8,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    perceptron_uart_ctrl_if.master bus,
    output logic busy
);

    state_t            state;
    wr_sel_t           target;
    logic [IDX_W-1:0]  cnt;
    logic [1:0]        last_err;
    logic              slot_load;
    logic [7:0]        slot_data;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              tmo_hit;

    // The bias takes a single byte; weights and inputs take N_INPUTS bytes.
    function automatic logic load_last(input wr_sel_t sel, input logic [IDX_W-1:0] idx);
        return (sel == SEL_B) || (idx == IDX_W'(N_INPUTS - 1));
    endfunction

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Idle-cycle counter for a partially received payload; restarts on every byte.
    always_ff @(posedge clk) begin
        if (rst || state != S_LOAD || bus.rx_valid) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    // Command FSM with registered write/start strobes and reply-slot load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            target    <= SEL_W;
            cnt       <= '0;
            last_err  <= ERR_NONE;
            slot_load <= 1'b0;
            slot_data <= 8'h00;
            wr_en     <= 1'b0;
            wr_sel    <= 2'd0;
            wr_idx    <= '0;
            wr_data   <= '0;
            start     <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            start     <= 1'b0;
            slot_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            OP_W: begin
                                target <= SEL_W;
                                cnt    <= '0;
                                state  <= S_LOAD;
                            end
                            OP_X: begin
                                target <= SEL_X;
                                cnt    <= '0;
                                state  <= S_LOAD;
                            end
                            OP_B: begin
                                target <= SEL_B;
                                cnt    <= '0;
                                state  <= S_LOAD;
                            end
                            OP_R: begin
                                state <= S_RUN;
                            end
                            OP_S: begin
                                slot_load <= 1'b1;
                                slot_data <= status_byte(last_err);
                                last_err  <= ERR_NONE;
                                state     <= S_SEND;
                            end
                            default: begin
                                last_err <= ERR_OPC;
                                state    <= S_ERR;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (bus.rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_sel  <= target;
                        wr_idx  <= cnt;
                        wr_data <= bus.rx_data;
                        if (load_last(target, cnt)) begin
                            slot_load <= 1'b1;
                            slot_data <= ACK;
                            state     <= S_SEND;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Partial command is abandoned; earlier writes stay in place.
                        last_err <= ERR_TMO;
                        state    <= S_ERR;
                    end
                end
                S_RUN: begin
                    start <= 1'b1;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A byte arriving while the core computes is lost; the result still goes out.
                    if (bus.rx_valid) begin
                        last_err <= ERR_OVR;
                    end
                    if (bus.p_done) begin
                        slot_load <= 1'b1;
                        slot_data <= bus.p_result;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.rx_valid) begin
                        last_err <= ERR_OVR;
                    end
                    // The slot fires tx_start on this same condition.
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    slot_load <= 1'b1;
                    slot_data <= NAK;
                    state     <= S_SEND;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    perceptron_tx_slot u_tx_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_data (slot_data),
        .send      (state == S_SEND),
        .tx_busy   (bus.tx_busy),
        .tx_data   (bus.tx_data),
        .tx_start  (bus.tx_start)
    );

    assign bus.p_wr_en   = wr_en;
    assign bus.p_wr_sel  = wr_sel;
    assign bus.p_wr_idx  = wr_idx;
    assign bus.p_wr_data = wr_data;
    assign bus.p_start   = start;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Self-checking bench for perceptron_uart_ctrl: table of load/status commands
// plus hand-written run, backpressure, overrun, reset and timeout sequences.
module tb_perceptron_uart_ctrl;
    import perceptron_pkg::*;

    localparam int N_IN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int checks = 0;
    int errors = 0;
    int tx_cnt = 0;
    int pstart_cnt = 0;

    logic [13:0] wq[$];
    logic [7:0]  tq[$];

    typedef struct packed {
        logic [7:0]  op;
        logic [2:0]  n;
        logic [31:0] pl;
        logic [1:0]  sel;
        logic [7:0]  reply;
    } vec_t;

    vec_t vecs[8];

    perceptron_uart_ctrl_if #(.DATA_W(8), .IDX_W(4)) bus ();

    perceptron_uart_ctrl #(
        .N_INPUTS       (N_IN),
        .DATA_W         (8),
        .IDX_W          (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((wq.size() != 0 || tq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain"}, wq.size() + tq.size(), 0);
        wq.delete();
        tq.delete();
        @(posedge clk);
        #1;
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic pulse_done(input logic [7:0] r);
        @(posedge clk);
        #1;
        bus.p_done   = 1'b1;
        bus.p_result = r;
        @(posedge clk);
        #1;
        bus.p_done = 1'b0;
    endtask

    initial begin
        int n0;
        logic [7:0] b;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        bus.p_done   = 1'b0;
        bus.p_result = 8'h00;

        vecs[0] = '{op: 8'h57, n: 3'd4, pl: {8'd40, 8'd30, 8'd20, 8'd10}, sel: 2'd0, reply: 8'h06};
        vecs[1] = '{op: 8'h58, n: 3'd4, pl: {8'd4, 8'd3, 8'd2, 8'd1},     sel: 2'd1, reply: 8'h06};
        vecs[2] = '{op: 8'h42, n: 3'd1, pl: {24'd0, 8'hF0},               sel: 2'd2, reply: 8'h06};
        vecs[3] = '{op: 8'h7A, n: 3'd0, pl: 32'd0,                        sel: 2'd0, reply: 8'hEE};
        vecs[4] = '{op: 8'h53, n: 3'd0, pl: 32'd0,                        sel: 2'd0, reply: 8'h01};
        vecs[5] = '{op: 8'h53, n: 3'd0, pl: 32'd0,                        sel: 2'd0, reply: 8'h00};
        vecs[6] = '{op: 8'h00, n: 3'd0, pl: 32'd0,                        sel: 2'd0, reply: 8'hEE};
        vecs[7] = '{op: 8'h53, n: 3'd0, pl: 32'd0,                        sel: 2'd0, reply: 8'h01};

        // Scoreboard monitor: every write strobe and tx_start is matched against queues.
        fork
            forever begin
                @(negedge clk);
                if (bus.p_wr_en) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL wr_unexpected got %0h want none", {bus.p_wr_sel, bus.p_wr_idx, bus.p_wr_data});
                    end else begin
                        logic [13:0] e;
                        e = wq.pop_front();
                        if ({bus.p_wr_sel, bus.p_wr_idx, bus.p_wr_data} !== e) begin
                            errors++;
                            $display("FAIL wr got %0h want %0h", {bus.p_wr_sel, bus.p_wr_idx, bus.p_wr_data}, e);
                        end
                    end
                end
                if (bus.tx_start) begin
                    tx_cnt++;
                    checks++;
                    if (tq.size() == 0) begin
                        errors++;
                        $display("FAIL tx_unexpected got %0h want none", bus.tx_data);
                    end else begin
                        logic [7:0] e;
                        e = tq.pop_front();
                        if (bus.tx_data !== e) begin
                            errors++;
                            $display("FAIL tx got %0h want %0h", bus.tx_data, e);
                        end
                    end
                end
                if (bus.p_start) pstart_cnt++;
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_outs", {bus.tx_start, bus.p_wr_en, bus.p_start, bus.p_wr_sel}, 0);
        check("rst_data", {bus.tx_data, bus.p_wr_data, 4'(bus.p_wr_idx)}, 0);

        // Table-driven commands
        for (int v = 0; v < 8; v++) begin
            tq.push_back(vecs[v].reply);
            send_byte(vecs[v].op);
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                b = vecs[v].pl[8*i +: 8];
                wq.push_back({vecs[v].sel, 4'(i), b});
                send_byte(b);
            end
            wait_drain($sformatf("vec%0d", v), 100);
        end

        // Run: p_start one cycle after the opcode edge, tx_start one cycle after p_done
        n0 = pstart_cnt;
        tq.push_back(8'h01);
        send_byte(OP_R);
        check("run_pstart_early", bus.p_start, 0);
        @(posedge clk);
        #1;
        check("run_pstart", bus.p_start, 1);
        @(posedge clk);
        #1;
        check("run_pstart_width", bus.p_start, 0);
        repeat (3) @(posedge clk);
        pulse_done(8'h01);
        check("run_tx_early", bus.tx_start, 0);
        @(posedge clk);
        #1;
        check("run_tx_start", {bus.tx_start, bus.tx_data}, {1'b1, 8'h01});
        wait_drain("run", 20);
        check("run_pstart_cnt", pstart_cnt - n0, 1);

        // p_done outside WAIT_DONE is ignored
        n0 = tx_cnt;
        pulse_done(8'h99);
        repeat (5) @(posedge clk);
        #1;
        check("stray_done", tx_cnt - n0, 0);
        check("stray_busy", busy, 0);

        // Transmitter backpressure
        bus.tx_busy = 1'b1;
        wq.push_back({2'd2, 4'd0, 8'h33});
        tq.push_back(8'h06);
        send_byte(OP_B);
        send_byte(8'h33);
        n0 = tx_cnt;
        repeat (50) @(posedge clk);
        #1;
        check("bp_hold", tx_cnt - n0, 0);
        check("bp_busy", busy, 1);
        bus.tx_busy = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release", {bus.tx_start, bus.tx_data}, {1'b1, 8'h06});
        @(posedge clk);
        #1;
        check("bp_single", {bus.tx_start, 8'(tx_cnt - n0)}, {1'b0, 8'd1});
        wait_drain("bp", 20);

        // Overrun during WAIT_DONE: byte dropped, result still sent
        tq.push_back(8'h2A);
        send_byte(OP_R);
        repeat (2) @(posedge clk);
        send_byte(OP_W);
        pulse_done(8'h2A);
        wait_drain("ovr", 20);
        tq.push_back(8'h01);
        send_byte(OP_S);
        wait_drain("ovr_status", 20);

        // Simultaneous rx_valid and p_done
        tq.push_back(8'h55);
        send_byte(OP_R);
        repeat (3) @(posedge clk);
        #1;
        bus.p_done   = 1'b1;
        bus.p_result = 8'h55;
        bus.rx_data  = OP_B;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.p_done   = 1'b0;
        bus.rx_valid = 1'b0;
        wait_drain("simul", 20);
        tq.push_back(8'h01);
        send_byte(OP_S);
        wait_drain("simul_status", 20);

        // Reset mid-payload: no reply, error code cleared
        tq.push_back(8'hEE);
        send_byte(8'h7A);
        wait_drain("pre_rst", 20);
        wq.push_back({2'd1, 4'd0, 8'h11});
        wq.push_back({2'd1, 4'd1, 8'h22});
        send_byte(OP_X);
        send_byte(8'h11);
        send_byte(8'h22);
        n0 = tx_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {bus.tx_start, bus.p_wr_en, bus.p_start, bus.p_wr_sel, bus.tx_data, bus.p_wr_data}, 0);
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_noreply", tx_cnt - n0, 0);
        check("mid_rst_writes", wq.size(), 0);
        tq.push_back(8'h00);
        send_byte(OP_S);
        wait_drain("post_rst_status", 20);

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
        // Inter-byte timeout aborts the partial load
        wq.push_back({2'd1, 4'd0, 8'h05});
        tq.push_back(8'hEE);
        send_byte(OP_X);
        send_byte(8'h05);
        wait_drain("tmo", 300);
        tq.push_back(8'h01);
        send_byte(OP_S);
        wait_drain("tmo_status", 20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
